gray_step_checker: RTL



---
 rtl/gray_step_checker_pkg.sv | 13 +
 rtl/gray_to_binary.sv | 19 +
 rtl/one_hot_index.sv | 23 ++
 rtl/gray_step_checker.sv | 138 +++++++++++++
 4 files changed

// File: rtl/gray_step_checker_pkg.sv
// Shared definitions for the Gray-code step checker.
// The word width is common to the pattern counter and Gray stages.
package gray_step_checker_pkg;

   localparam int GRAY_WIDTH = 12;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TRACK  = 2'd1,
      ST_RESYNC = 2'd2
   } state_t;

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray_to_binary
   import gray_step_checker_pkg::*;
#(
   parameter int WIDTH = GRAY_WIDTH
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   always_comb begin
      bin = '0;
      for (int i = 0; i < WIDTH; i++) begin
         bin[i] = ^(gray >> i);
      end
   end

endmodule

// File: rtl/one_hot_index.sv
// Position of the set bit in a one-hot vector.
// The result is only meaningful when exactly one bit is set.
module one_hot_index
   import gray_step_checker_pkg::*;
#(
   parameter int WIDTH = GRAY_WIDTH
) (
   input  logic [WIDTH-1:0]         vec,
   output logic [$clog2(WIDTH)-1:0] idx
);

   function automatic logic [$clog2(WIDTH)-1:0] pos(
      input logic [WIDTH-1:0] v
   );
      pos = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) pos = ($clog2(WIDTH))'(i);
      end
   endfunction

   assign idx = pos(vec);

endmodule

// File: rtl/gray_step_checker.sv
// Checks that consecutive Gray samples differ by at most one bit,
// reporting step index and direction, and counting illegal jumps.
module gray_step_checker
   import gray_step_checker_pkg::*;
#(
   parameter int WIDTH     = GRAY_WIDTH,
   parameter int ERR_CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enb,
   input  logic                     clr,
   input  logic [WIDTH-1:0]         gray_in,
   output logic [WIDTH-1:0]         bin_out,
   output logic                     step,
   output logic [$clog2(WIDTH)-1:0] step_idx,
   output logic                     dir,
   output logic                     err,
   output logic [ERR_CNT_W-1:0]     err_cnt,
   output logic                     locked
);

   localparam int IW = $clog2(WIDTH);

   state_t               state_q;
   state_t               state_d;
   logic [WIDTH-1:0]     ref_q;
   logic [WIDTH-1:0]     bin_q;
   logic [WIDTH-1:0]     new_bin;
   logic [WIDTH-1:0]     bin_inc;
   logic [WIDTH-1:0]     diff;
   logic [IW-1:0]        oh_idx;
   logic                 any_diff;
   logic                 single;
   logic                 multi;
   logic                 step_d;
   logic                 err_d;
   logic [IW-1:0]        idx_q;
   logic [IW-1:0]        idx_d;
   logic                 dir_q;
   logic                 dir_d;
   logic                 step_q;
   logic                 err_q;
   logic                 locked_q;
   logic [ERR_CNT_W-1:0] cnt_q;
   logic [ERR_CNT_W-1:0] cnt_d;

   gray_to_binary #(.WIDTH(WIDTH)) u_g2b (
      .gray (gray_in),
      .bin  (new_bin)
   );

   one_hot_index #(.WIDTH(WIDTH)) u_idx (
      .vec (diff),
      .idx (oh_idx)
   );

   // x & (x-1) clears the lowest set bit: zero means at most one bit set
   assign diff     = gray_in ^ ref_q;
   assign any_diff = |diff;
   assign single   = any_diff && ((diff & (diff - 1'b1)) == '0);
   assign multi    = any_diff && !single;
   assign bin_inc  = bin_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (enb) begin
         unique case (state_q)
            ST_IDLE:   state_d = ST_TRACK;
            ST_TRACK:  if (multi) state_d = ST_RESYNC;
            ST_RESYNC: state_d = ST_TRACK;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      step_d = 1'b0;
      err_d  = 1'b0;
      idx_d  = idx_q;
      dir_d  = dir_q;
      cnt_d  = cnt_q;
      if (enb && state_q == ST_TRACK) begin
         step_d = single;
         err_d  = multi;
      end
      if (step_d) begin
         idx_d = oh_idx;
         dir_d = (new_bin == bin_inc);
      end
      if (clr) begin
         cnt_d = '0;
      end else if (err_d && cnt_q != '1) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_q    <= '0;
         bin_q    <= '0;
         step_q   <= 1'b0;
         err_q    <= 1'b0;
         idx_q    <= '0;
         dir_q    <= 1'b0;
         cnt_q    <= '0;
         locked_q <= 1'b0;
      end else begin
         if (enb) begin
            ref_q <= gray_in;
            bin_q <= new_bin;
         end
         step_q   <= step_d;
         err_q    <= err_d;
         idx_q    <= idx_d;
         dir_q    <= dir_d;
         cnt_q    <= cnt_d;
         locked_q <= (state_d == ST_TRACK);
      end
   end

   assign bin_out  = bin_q;
   assign step     = step_q;
   assign step_idx = idx_q;
   assign dir      = dir_q;
   assign err      = err_q;
   assign err_cnt  = cnt_q;
   assign locked   = locked_q;

endmodule
